// File: rtl/div_pipe_r.sv
// div_pipe_r: pipelined restoring integer divider that accepts one new division per cycle.
// Define DIV_SIGNED_EN to compile in two's-complement mode (abs input stage, sign bits, output negation).
module div_pipe_r #(
    parameter int DW     = 32,
    parameter int N_PIPE = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic [DW-1:0] A_i,
    input  logic [DW-1:0] B_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] div_quotient_o,
    output logic [DW-1:0] div_remainder_o,
    output logic          div_zero_o
);
    localparam int SB = DW / N_PIPE;

    // vld_p[0] input stage, vld_p[1..N_PIPE] iteration stages, vld_p[N_PIPE+1] sign-fix stage
    logic [N_PIPE+1:0] vld_p;
    logic [DW-1:0]     rem_p   [N_PIPE+1];
    logic [DW-1:0]     quo_p   [N_PIPE+1];
    logic [DW-1:0]     dvs_p   [N_PIPE+1];
    logic              zero_p  [N_PIPE+1];
    logic [DW-1:0]     rem_nxt [1:N_PIPE];
    logic [DW-1:0]     quo_nxt [1:N_PIPE];
    logic [DW-1:0]     q_fix;
    logic [DW-1:0]     r_fix;
    logic              zero_fix;
    logic [DW-1:0]     a_in;
    logic [DW-1:0]     b_in;

    // Resolves SB quotient bits starting at bit 'top'; the divisor is shifted in 2*DW bits.
    function automatic logic [2*DW-1:0] div_step(input logic [DW-1:0] rem, input logic [DW-1:0] quo,
                                                 input logic [DW-1:0] dvs, input int top);
        logic [2*DW-1:0] r_w;
        logic [2*DW-1:0] d_w;
        logic [DW-1:0]   q_w;
        r_w = {{DW{1'b0}}, rem};
        q_w = quo;
        for (int j = 0; j < SB; j++) begin
            d_w = {{DW{1'b0}}, dvs} << (top - j);
            if (r_w >= d_w) begin
                r_w = r_w - d_w;
                q_w = {q_w[DW-2:0], 1'b1};
            end else begin
                q_w = {q_w[DW-2:0], 1'b0};
            end
        end
        return {q_w, r_w[DW-1:0]};
    endfunction

`ifdef DIV_SIGNED_EN
    logic qneg_p [N_PIPE+1];
    logic rneg_p [N_PIPE+1];
    logic sa_in;
    logic sb_in;

    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
        logic signed [DW-1:0] s;
        s = v;
        return neg ? -s : s;
    endfunction

    assign sa_in = signed_i & A_i[DW-1];
    assign sb_in = signed_i & B_i[DW-1];
    assign a_in  = cond_neg(A_i, sa_in);
    assign b_in  = cond_neg(B_i, sb_in);
`else
    logic unused_signed;
    assign unused_signed = signed_i;
    assign a_in          = A_i;
    assign b_in          = B_i;
`endif

    always_comb begin
        for (int k = 1; k <= N_PIPE; k++) begin
            {quo_nxt[k], rem_nxt[k]} = div_step(rem_p[k-1], quo_p[k-1], dvs_p[k-1],
                                                DW - 1 - (k - 1) * SB);
        end
    end

    // input stage -> iteration stages -> sign-fix stage
    always_ff @(posedge clk_i) begin
        if (start_i) begin
            rem_p[0]  <= a_in;
            quo_p[0]  <= '0;
            dvs_p[0]  <= b_in;
            zero_p[0] <= (B_i == '0);
`ifdef DIV_SIGNED_EN
            qneg_p[0] <= sa_in ^ sb_in;
            rneg_p[0] <= sa_in;
`endif
        end
        for (int k = 1; k <= N_PIPE; k++) begin
            rem_p[k]  <= rem_nxt[k];
            quo_p[k]  <= quo_nxt[k];
            dvs_p[k]  <= dvs_p[k-1];
            zero_p[k] <= zero_p[k-1];
`ifdef DIV_SIGNED_EN
            qneg_p[k] <= qneg_p[k-1];
            rneg_p[k] <= rneg_p[k-1];
`endif
        end
        zero_fix <= zero_p[N_PIPE];
`ifdef DIV_SIGNED_EN
        q_fix <= zero_p[N_PIPE] ? '1 : cond_neg(quo_p[N_PIPE], qneg_p[N_PIPE]);
        r_fix <= cond_neg(rem_p[N_PIPE], rneg_p[N_PIPE]);
`else
        q_fix <= zero_p[N_PIPE] ? '1 : quo_p[N_PIPE];
        r_fix <= rem_p[N_PIPE];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[N_PIPE:0], start_i};
        end
    end

    // output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o         <= 1'b0;
            div_quotient_o  <= '0;
            div_remainder_o <= '0;
            div_zero_o      <= 1'b0;
        end else begin
            valid_o <= vld_p[N_PIPE+1];
            if (vld_p[N_PIPE+1]) begin
                div_quotient_o  <= q_fix;
                div_remainder_o <= r_fix;
                div_zero_o      <= zero_fix;
            end
        end
    end

    assign ready_o = ~(|vld_p) & ~valid_o;

endmodule

// File: tb/tb_div_pipe_r.sv
// Testbench for div_pipe_r: directed DW=32/N_PIPE=8 scenarios plus a randomised DW=16 sweep
// over several pipeline depths, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_pipe_r;
`ifdef DIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif
    localparam int NPS [4] = '{1, 2, 4, 16};
    localparam int NOPS    = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        start, sgn;
    logic [31:0] a, b;
    logic        ready, valid;
    logic [31:0] quo, rem;
    logic        zero;

    logic        s_start, s_sgn;
    logic [15:0] s_a, s_b;
    logic        s_rdy [4];
    logic        s_vld [4];
    logic [15:0] s_q   [4];
    logic [15:0] s_r   [4];
    logic        s_z   [4];

    int checks = 0;
    int errors = 0;
    int t_smp;
    logic [31:0] res_q[$];
    logic [31:0] res_r[$];
    logic        res_z[$];
    int          res_t[$];

    div_pipe_r #(.DW(32), .N_PIPE(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn), .A_i(a), .B_i(b),
        .ready_o(ready), .valid_o(valid), .div_quotient_o(quo), .div_remainder_o(rem),
        .div_zero_o(zero)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        div_pipe_r #(.DW(16), .N_PIPE(NPS[g])) u_dut16 (
            .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .signed_i(s_sgn), .A_i(s_a), .B_i(s_b),
            .ready_o(s_rdy[g]), .valid_o(s_vld[g]), .div_quotient_o(s_q[g]),
            .div_remainder_o(s_r[g]), .div_zero_o(s_z[g])
        );
    end

    // Reference: plain integer division on w-bit operands, truncating toward zero.
    function automatic void ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                                    input int w, output logic [31:0] rq, output logic [31:0] rr,
                                    output logic rz);
        longint mask, ma, mb, qq, rm;
        mask = (longint'(1) << w) - 1;
        ma   = longint'(ra) & mask;
        mb   = longint'(rb) & mask;
        rz   = (mb == 0);
        if (rz) begin
            rq = 32'(mask);
            rr = 32'(ma);
            return;
        end
        if (rs) begin
            if (ma >= (longint'(1) << (w - 1))) ma = ma - (longint'(1) << w);
            if (mb >= (longint'(1) << (w - 1))) mb = mb - (longint'(1) << w);
        end
        qq = ma / mb;
        rm = ma % mb;
        rq = 32'(qq & mask);
        rr = 32'(rm & mask);
    endfunction

    task automatic send32(input logic [31:0] va, input logic [31:0] vb, input logic vs);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; sgn = vs;
        t_smp = cyc + 1;
    endtask

    task automatic idle32();
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; sgn = 1'($urandom);
    endtask

    task automatic collect32(input int n, input int budget);
        res_q.delete(); res_r.delete(); res_z.delete(); res_t.delete();
        for (int i = 0; i < budget && res_q.size() < n; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                res_q.push_back(quo); res_r.push_back(rem);
                res_z.push_back(zero); res_t.push_back(cyc);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sgn = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (quo !== 32'h0) begin errors++; $display("FAIL reset_q got %h want 0", quo); end
        checks++; if (rem !== 32'h0) begin errors++; $display("FAIL reset_r got %h want 0", rem); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int t0;
        send32(32'd100, 32'd7, 1'b0);
        t0 = t_smp;
        idle32();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_busy ready got %b want 0", ready); end
        collect32(1, 30);
        checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", res_q.size()); end
        checks++; if (res_t[0] - t0 !== 10) begin errors++; $display("FAIL basic_latency got %0d want 10", res_t[0] - t0); end
        checks++; if (res_q[0] !== 32'd14) begin errors++; $display("FAIL basic_q got %0d want 14", res_q[0]); end
        checks++; if (res_r[0] !== 32'd2) begin errors++; $display("FAIL basic_r got %0d want 2", res_r[0]); end
        checks++; if (res_z[0] !== 1'b0) begin errors++; $display("FAIL basic_zero got %b want 0", res_z[0]); end
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b want 1", ready); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_pulse valid got %b want 0", valid); end
        checks++; if (quo !== 32'd14) begin errors++; $display("FAIL basic_hold q got %0d want 14", quo); end
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [31:0] eq [3] = '{32'd100, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] er [3] = '{32'd0, 32'd0, 32'd5};
        send32(32'd1000, 32'd10, 1'b0);
        t0 = t_smp;
        send32(32'hFFFF_FFFF, 32'd1, 1'b0);
        send32(32'd5, 32'd9, 1'b0);
        idle32();
        collect32(3, 30);
        checks++; if (res_q.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", res_q.size()); end
        checks++; if (res_t[0] - t0 !== 10) begin errors++; $display("FAIL b2b_latency got %0d want 10", res_t[0] - t0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (res_t[i] !== t0 + 10 + i) begin errors++; $display("FAIL b2b_slot%0d got %0d want %0d", i, res_t[i], t0 + 10 + i); end
            checks++; if (res_q[i] !== eq[i]) begin errors++; $display("FAIL b2b_q%0d got %h want %h", i, res_q[i], eq[i]); end
            checks++; if (res_r[i] !== er[i]) begin errors++; $display("FAIL b2b_r%0d got %h want %h", i, res_r[i], er[i]); end
            checks++; if (res_z[i] !== 1'b0) begin errors++; $display("FAIL b2b_zero%0d got %b want 0", i, res_z[i]); end
        end
    endtask

    task automatic test_div_zero();
        for (int m = 0; m < 2; m++) begin
            send32(32'h1234_5678, 32'd0, 1'(m));
            idle32();
            collect32(1, 30);
            checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL dz%0d_count got %0d want 1", m, res_q.size()); end
            checks++; if (res_q[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz%0d_q got %h want ffffffff", m, res_q[0]); end
            checks++; if (res_r[0] !== 32'h1234_5678) begin errors++; $display("FAIL dz%0d_r got %h want 12345678", m, res_r[0]); end
            checks++; if (res_z[0] !== 1'b1) begin errors++; $display("FAIL dz%0d_flag got %b want 1", m, res_z[0]); end
        end
        send32(32'hF000_0001, 32'd0, 1'b1);
        idle32();
        collect32(1, 30);
        checks++; if (res_r[0] !== 32'hF000_0001) begin errors++; $display("FAIL dz_neg_r got %h want f0000001", res_r[0]); end
    endtask

    task automatic test_signed();
        logic [31:0] eq [3];
        logic [31:0] er [3];
        if (SGN_EN) begin
            eq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
            er = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        end else begin
            eq = '{32'h7FFF_FFFC, 32'd0, 32'd0};
            er = '{32'd1, 32'd7, 32'h8000_0000};
        end
        send32(32'hFFFF_FFF9, 32'd2, 1'b1);
        send32(32'd7, 32'hFFFF_FFFE, 1'b1);
        send32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        idle32();
        collect32(3, 30);
        checks++; if (res_q.size() !== 3) begin errors++; $display("FAIL sgn_count got %0d want 3", res_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (res_q[i] !== eq[i]) begin errors++; $display("FAIL sgn_q%0d got %h want %h", i, res_q[i], eq[i]); end
            checks++; if (res_r[i] !== er[i]) begin errors++; $display("FAIL sgn_r%0d got %h want %h", i, res_r[i], er[i]); end
            checks++; if (res_z[i] !== 1'b0) begin errors++; $display("FAIL sgn_zero%0d got %b want 0", i, res_z[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int nv, nr;
        send32(32'd123456, 32'd77, 1'b0);
        idle32();
        repeat (4) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rmid_busy ready got %b want 0", ready); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid); end
        checks++; if (quo !== 32'h0) begin errors++; $display("FAIL rmid_q got %h want 0", quo); end
        checks++; if (rem !== 32'h0) begin errors++; $display("FAIL rmid_r got %h want 0", rem); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rmid_zero got %b want 0", zero); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", ready); end
        @(negedge clk); rst_n = 1'b1;
        nv = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid) nv++;
            if (!ready) nr++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL rmid_ghost valids got %0d want 0", nv); end
        checks++; if (nr !== 0) begin errors++; $display("FAIL rmid_notready cycles got %0d want 0", nr); end
    endtask

    task automatic test_sweep();
        logic [15:0] oa [NOPS];
        logic [15:0] ob [NOPS];
        logic        os [NOPS];
        int          ot [NOPS];
        int          got [4];
        logic [31:0] eq, er;
        logic        ez;
        int          k;
        got = '{default: 0};
        for (int c = 0; c < NOPS + 30; c++) begin
            @(negedge clk);
            if (c < NOPS) begin
                case ($urandom % 6)
                    0: oa[c] = 16'h8000;
                    1: oa[c] = 16'd0;
                    default: oa[c] = 16'($urandom);
                endcase
                case ($urandom % 6)
                    0: ob[c] = 16'd0;
                    1: ob[c] = 16'hFFFF;
                    2: ob[c] = 16'd1;
                    3: ob[c] = 16'($urandom % 16);
                    default: ob[c] = 16'($urandom);
                endcase
                os[c] = 1'($urandom);
                ot[c] = cyc + 1;
                s_start = 1'b1; s_a = oa[c]; s_b = ob[c]; s_sgn = os[c];
            end else begin
                s_start = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom); s_sgn = 1'($urandom);
            end
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (s_vld[d]) begin
                    k = got[d];
                    if (k >= NOPS) begin
                        checks++; errors++;
                        $display("FAIL sweep_extra np=%0d result %0d beyond %0d issued", NPS[d], k, NOPS);
                    end else begin
                        ref_div({16'h0, oa[k]}, {16'h0, ob[k]}, SGN_EN & os[k], 16, eq, er, ez);
                        checks++; if (s_q[d] !== eq[15:0]) begin errors++; $display("FAIL sweep_q np=%0d op%0d %h/%h s=%b got %h want %h", NPS[d], k, oa[k], ob[k], os[k], s_q[d], eq[15:0]); end
                        checks++; if (s_r[d] !== er[15:0]) begin errors++; $display("FAIL sweep_r np=%0d op%0d %h/%h s=%b got %h want %h", NPS[d], k, oa[k], ob[k], os[k], s_r[d], er[15:0]); end
                        checks++; if (s_z[d] !== ez) begin errors++; $display("FAIL sweep_zero np=%0d op%0d got %b want %b", NPS[d], k, s_z[d], ez); end
                        checks++; if (cyc - ot[k] !== NPS[d] + 2) begin errors++; $display("FAIL sweep_latency np=%0d op%0d got %0d want %0d", NPS[d], k, cyc - ot[k], NPS[d] + 2); end
                    end
                    got[d]++;
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++; if (got[d] !== NOPS) begin errors++; $display("FAIL sweep_count np=%0d got %0d want %0d", NPS[d], got[d], NOPS); end
            checks++; if (s_rdy[d] !== 1'b1) begin errors++; $display("FAIL sweep_ready np=%0d got %b want 1", NPS[d], s_rdy[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_signed();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
